// File: rtl/fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// fft_bitrev_reorder
//
// Streaming reorder buffer for the output of a pipelined N-point FFT
// (N = 2**logn). Samples arrive in bit-reversed order, one complex word per
// valid cycle. Gaps of any length are allowed. Each sample is written to a
// ping-pong bank at its natural-order address. A full bank is then drained in
// natural order, one sample per cycle with no gaps.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   di_re/di_im carry the next bit-reversed sample of the frame
//   di_re      real part of the input sample     (FLOAT_PRECISION bits, opaque)
//   di_im      imaginary part of the input sample (FLOAT_PRECISION bits, opaque)
//   out_valid  do_re/do_im/out_idx are valid this cycle
//   do_re      real part of the natural-order output sample
//   do_im      imaginary part of the natural-order output sample
//   out_idx    natural-order index k of the current output sample
//   out_last   high with the sample where k = N-1
// -----------------------------------------------------------------------------
module fft_bitrev_reorder #(
  parameter int FLOAT_PRECISION = 64,
  parameter int logn            = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [FLOAT_PRECISION-1:0] di_re,
  input  logic [FLOAT_PRECISION-1:0] di_im,
  output logic                       out_valid,
  output logic [FLOAT_PRECISION-1:0] do_re,
  output logic [FLOAT_PRECISION-1:0] do_im,
  output logic [logn-1:0]            out_idx,
  output logic                       out_last
);

  localparam int              N        = 1 << logn;
  localparam int              DW       = 2 * FLOAT_PRECISION;
  localparam logic [logn-1:0] IDX_LAST = '1;

  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [logn-1:0] bitrev(input logic [logn-1:0] a);
    logic [logn-1:0] r;
    for (int i = 0; i < logn; i++) r[i] = a[logn-1-i];
    return r;
  endfunction

  // Two banks of N entries. The address is {bank, index}.
  logic [DW-1:0] mem [2*N];

  // Write side
  logic [logn-1:0] wcnt;
  logic            wbank;
  logic [1:0]      full;

  // Read side
  state_t          state, state_nxt;
  logic            rbank, rbank_nxt;
  logic [logn-1:0] rcnt, rcnt_nxt;
  logic            rd_en;
  logic            rd_bank;
  logic [logn-1:0] rd_addr;
  logic            clr_full;

  // NOTE: the bank array has no reset. Stale contents are never presented,
  // because a bank is read only after a full frame has been written into it.
  always_ff @(posedge clk) begin
    if (in_valid) mem[{wbank, bitrev(wcnt)}] <= {di_re, di_im};
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, whatever order the blocks run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt  <= '0;
      wbank <= 1'b0;
      full  <= '0;
    end else begin
      if (clr_full) full[rbank] <= 1'b0;
      // The frame-completing write comes after the clear. The writer is never
      // on the bank being drained, so the two never touch the same flag.
      if (in_valid) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == IDX_LAST) begin
          full[wbank] <= 1'b1;
          wbank       <= ~wbank;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rbank <= 1'b0;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      rbank <= rbank_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  // IDLE presents k = 0 on the same edge that it leaves for READ. This gives
  // one cycle of latency after the frame's last write. It also keeps out_valid
  // high when a bank fills on the edge that presents the other bank's k = N-1.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_nxt = state;
    rbank_nxt = rbank;
    rcnt_nxt  = rcnt;
    rd_en     = 1'b0;
    rd_bank   = rbank;
    rd_addr   = rcnt;
    clr_full  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|full) begin
          // When both banks are full, the one at wbank holds the older frame
          // (the writer has already wrapped back to it).
          rd_en     = 1'b1;
          rd_bank   = full[wbank] ? wbank : ~wbank;
          rd_addr   = '0;
          rbank_nxt = rd_bank;
          rcnt_nxt  = logn'(1);
          state_nxt = READ;
        end
      end
      READ: begin
        rd_en    = 1'b1;
        rcnt_nxt = rcnt + 1'b1;
        if (rcnt == IDX_LAST) begin
          clr_full  = 1'b1;
          rbank_nxt = ~rbank;
          state_nxt = full[~rbank] ? READ : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      do_re     <= '0;
      do_im     <= '0;
      out_idx   <= '0;
    end else begin
      out_valid <= rd_en;
      out_last  <= rd_en && (rd_addr == IDX_LAST);
      if (rd_en) begin
        {do_re, do_im} <= mem[{rd_bank, rd_addr}];
        out_idx        <= rd_addr;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// tb_fft_bitrev_reorder
//
// Scoreboard bench for fft_bitrev_reorder (logn = 8). When a frame's last
// sample is driven, the bench queues the expected natural-order outputs and
// the edge on which k = 0 must appear. A negedge monitor pops the queue and
// compares each output sample against it.
// -----------------------------------------------------------------------------
module tb_fft_bitrev_reorder;

  localparam int FP   = 64;
  localparam int LOGN = 8;
  localparam int N    = 1 << LOGN;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [FP-1:0]   di_re, di_im;
  logic            out_valid;
  logic [FP-1:0]   do_re, do_im;
  logic [LOGN-1:0] out_idx;
  logic            out_last;

  always #5 clk = ~clk;

  fft_bitrev_reorder #(.FLOAT_PRECISION(FP), .logn(LOGN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .di_re     (di_re),
    .di_im     (di_im),
    .out_valid (out_valid),
    .do_re     (do_re),
    .do_im     (do_im),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  typedef struct {
    logic [FP-1:0] re;
    logic [FP-1:0] im;
    int            idx;
    logic          last;
  } exp_t;

  exp_t          sb_q[$];
  int            start_q[$];
  logic [FP-1:0] frame_re[N];
  int            pos       = 0;
  int            next_free = 0;
  int            cyc       = 0;
  int            prev_cyc  = 0;
  int            total     = 0;
  int            bad       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic int rev(input int k);
    int r = 0;
    for (int i = 0; i < LOGN; i++) if (k & (1 << i)) r |= 1 << (LOGN - 1 - i);
    return r;
  endfunction

  // Drive one sample so that it is captured on the next rising edge.
  task automatic send(input logic [FP-1:0] re);
    exp_t e;
    int   start;
    in_valid      = 1'b1;
    di_re         = re;
    di_im         = ~re;
    frame_re[pos] = re;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (pos == N - 1) begin
      for (int k = 0; k < N; k++) begin
        e.re   = frame_re[rev(k)];
        e.im   = ~frame_re[rev(k)];
        e.idx  = k;
        e.last = (k == N - 1);
        sb_q.push_back(e);
      end
      start = (cyc + 1 > next_free) ? cyc + 1 : next_free;
      start_q.push_back(start);
      next_free = start + N;
      pos = 0;
    end else begin
      pos++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_valid"}, 64'(out_valid), 64'd0);
    check({pfx, "_last"},  64'(out_last),  64'd0);
    check({pfx, "_re"},    do_re,          64'd0);
    check({pfx, "_im"},    do_im,          64'd0);
    check({pfx, "_idx"},   64'(out_idx),   64'd0);
  endtask

  // Asserted between edges, so the outputs must clear without any clock.
  task automatic pulse_reset(input string pfx);
    #2;
    rst = 1'b1;
    sb_q.delete();
    start_q.delete();
    pos       = 0;
    next_free = 0;
    #1;
    check_reset_outputs(pfx);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    int   s;
    if (!out_valid && out_last) check("stray_last", 64'd1, 64'd0);
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("do_re",    do_re,          e.re);
        check("do_im",    do_im,          e.im);
        check("out_idx",  64'(out_idx),   64'(e.idx));
        check("out_last", 64'(out_last),  64'(e.last));
        if (e.idx == 0) begin
          if (start_q.size() == 0) begin
            check("start_missing", 64'd1, 64'd0);
          end else begin
            s = start_q.pop_front();
            check("start_cycle", 64'(cyc), 64'(s));
          end
        end else begin
          check("contiguous", 64'(cyc), 64'(prev_cyc + 1));
        end
        prev_cyc = cyc;
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    di_re    = '0;
    di_im    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("init");
    rst = 1'b0;
    idle(3);

    // Single contiguous frame: re = j, im = ~j.
    for (int j = 0; j < N; j++) send(64'(j));
    wait_drain(N + 20);
    idle(5);

    // Two back-to-back frames; the second frame starts at base 1000.
    for (int j = 0; j < N; j++) send(64'(j));
    for (int j = 0; j < N; j++) send(64'(1000 + j));
    wait_drain(2 * N + 20);
    idle(5);

    // Gapped input: one valid sample every other cycle.
    for (int j = 0; j < N; j++) begin
      send(64'(3000 + j));
      idle(1);
    end
    wait_drain(N + 20);
    idle(5);

    // Long stall before the final sample of the frame.
    for (int j = 0; j < N - 1; j++) send(64'(5000 + j));
    idle(1000);
    send(64'(5000 + N - 1));
    wait_drain(N + 20);
    idle(5);

    // Reset after 100 samples, then a fresh frame mapped from position 0.
    for (int j = 0; j < 100; j++) send(64'(7000 + j));
    pulse_reset("rst_mid_in");
    for (int j = 0; j < N; j++) send(64'(9000 + j));
    wait_drain(N + 20);
    idle(5);

    // Reset while a frame is being output: nothing may follow it.
    for (int j = 0; j < N; j++) send(64'(11000 + j));
    idle(60);
    pulse_reset("rst_mid_out");
    idle(2 * N);

    // Reset leaves the bench quiet, so one more frame confirms a clean restart.
    for (int j = 0; j < N; j++) send(64'(13000 + (j * 7)));
    wait_drain(N + 20);
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
